// File: rtl/mips_pkg.sv
// Shared MIPS-core definitions: fetch FSM states, primary opcodes and reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump beats branch, branch beats sequential; all adds wrap mod 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;

  always_comb begin
    jump_target   = {pc_plus4[31:28], instr, 2'b00};
    branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    branch_target = pc_plus4 + branch_offset;
    next_pc       = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, issues one word at a
// time to the decoder and flags a sticky error when memory stops answering.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clock_in,
  input  logic        reset_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode_out,
  output logic        instr_valid_out,
  input  logic        exec_done_in,
  input  logic        branch_taken_in,
  input  logic        jump_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_err_out
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [CW-1:0] wait_cnt;
  logic          err;
  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;

  assign pc_plus4 = pc + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4     (pc_plus4),
    .instr        (instr[25:0]),
    .branch_taken (branch_taken_in),
    .jump         (jump_in),
    .next_pc      (next_pc)
  );

  // Resolve inputs are only honoured in ISSUE and ready only in REQ; every other
  // state simply ignores them, which also keeps HALT frozen until reset.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state    <= IDLE;
      pc       <= {RESET_PC[31:2], 2'b00};
      instr    <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready_in) begin
            instr    <= imem_rdata_in;
            wait_cnt <= '0;
            state    <= ISSUE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (exec_done_in) begin
            pc    <= {next_pc[31:2], 2'b00};
            state <= REQ;
          end
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    imem_req_out    = (state == REQ);
    instr_valid_out = (state == ISSUE);
    imem_addr_out   = pc;
    pc_out          = pc;
    pc_plus4_out    = pc_plus4;
    instr_out       = instr;
    opcode_out      = instr[31:26];
    fetch_err_out   = err;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, next-PC selection, wrap, timeout and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] rdata;
  logic        done;
  logic        br;
  logic        jmp;

  logic        req, valid, err;
  logic [31:0] addr, instr, pc, pc4;
  logic [5:0]  opc;

  logic        h_req, h_valid, h_err;
  logic [31:0] h_addr, h_instr, h_pc, h_pc4;
  logic [5:0]  h_opc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16)) dut (
    .clock_in(clk), .reset_in(rst),
    .imem_req_out(req), .imem_addr_out(addr),
    .imem_ready_in(ready), .imem_rdata_in(rdata),
    .instr_out(instr), .opcode_out(opc), .instr_valid_out(valid),
    .exec_done_in(done), .branch_taken_in(br), .jump_in(jmp),
    .pc_out(pc), .pc_plus4_out(pc4), .fetch_err_out(err)
  );

  // Second instance lives in the upper PC region to exercise the jump segment bits.
  fetch_unit #(.RESET_PC(32'h1000_0000), .MAX_WAIT(16)) dut_hi (
    .clock_in(clk), .reset_in(rst),
    .imem_req_out(h_req), .imem_addr_out(h_addr),
    .imem_ready_in(ready), .imem_rdata_in(rdata),
    .instr_out(h_instr), .opcode_out(h_opc), .instr_valid_out(h_valid),
    .exec_done_in(done), .branch_taken_in(br), .jump_in(jmp),
    .pc_out(h_pc), .pc_plus4_out(h_pc4), .fetch_err_out(h_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: memory answers this cycle, stage moves to ISSUE.
  task automatic fetch(input logic [31:0] word);
    ready = 1'b1;
    rdata = word;
    step();
    ready = 1'b0;
    rdata = 32'hDEAD_BEEF;
  endtask

  // From ISSUE: pulse done with the given resolve signals, stage moves to REQ.
  task automatic finish(input logic j, input logic b);
    done = 1'b1;
    jmp  = j;
    br   = b;
    step();
    done = 1'b0;
    jmp  = 1'b0;
    br   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    rdata = '0;
    done  = 1'b0;
    br    = 1'b0;
    jmp   = 1'b0;

    // Jump in the upper segment; jump wins over branch.
    do_reset();
    step();
    chk("hi_req_addr", h_addr, 32'h1000_0000);
    fetch(32'h0800_0040);
    chk("hi_opcode_j", {26'd0, h_opc}, 32'h0000_0002);
    finish(1'b1, 1'b1);
    chk("hi_jump_addr", h_addr, 32'h1000_0100);
    chk("hi_jump_req", {31'd0, h_req}, 32'd1);

    // Reset state.
    rst = 1'b1;
    step();
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_done_req", {31'd0, req}, 32'd1);
    chk("first_addr", addr, 32'h0000_0000);

    // Zero-wait fetch of addiu, sequential done.
    fetch(32'h2409_0005);
    chk("addiu_valid", {31'd0, valid}, 32'd1);
    chk("addiu_opcode", {26'd0, opc}, 32'h0000_0009);
    chk("addiu_instr", instr, 32'h2409_0005);
    chk("addiu_req_low", {31'd0, req}, 32'd0);
    chk("addiu_pc4", pc4, 32'h0000_0004);
    step();
    chk("issue_hold_valid", {31'd0, valid}, 32'd1);
    chk("issue_hold_instr", instr, 32'h2409_0005);
    finish(1'b0, 1'b0);
    chk("seq_addr", addr, 32'h0000_0004);
    chk("seq_valid_drop", {31'd0, valid}, 32'd0);

    // Jump to 0x10, then beq -1 taken / not taken.
    fetch(32'h0800_0004);
    finish(1'b1, 1'b0);
    chk("jump_addr", addr, 32'h0000_0010);
    fetch(32'h1000_FFFF);
    chk("beq_opcode", {26'd0, opc}, 32'h0000_0004);
    finish(1'b0, 1'b1);
    chk("beq_taken_addr", addr, 32'h0000_0010);
    fetch(32'h1000_FFFF);
    finish(1'b0, 1'b0);
    chk("beq_not_taken_addr", addr, 32'h0000_0014);

    // Resolve inputs outside ISSUE are ignored.
    done = 1'b1;
    jmp  = 1'b1;
    step();
    done = 1'b0;
    jmp  = 1'b0;
    chk("ignored_done_addr", addr, 32'h0000_0014);
    chk("ignored_done_req", {31'd0, req}, 32'd1);

    // Branch backwards to the top of memory, then wrap sequentially.
    fetch(32'h1000_FFF9);
    finish(1'b0, 1'b1);
    chk("neg_branch_addr", addr, 32'hFFFF_FFFC);
    chk("top_pc4_wrap", pc4, 32'h0000_0000);
    fetch(32'h2409_0005);
    finish(1'b0, 1'b0);
    chk("wrap_addr", addr, 32'h0000_0000);

    // Reset in ISSUE with ready active.
    fetch(32'h0800_0004);
    finish(1'b1, 1'b0);
    fetch(32'h8C08_0000);
    chk("lw_opcode", {26'd0, opc}, 32'h0000_0023);
    rst   = 1'b1;
    ready = 1'b1;
    done  = 1'b1;
    step();
    done  = 1'b0;
    chk("mid_rst_pc", pc, 32'h0000_0000);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_req", {31'd0, req}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0000_0000);
    rst   = 1'b0;
    ready = 1'b0;
    step();
    chk("post_rst_req", {31'd0, req}, 32'd1);

    // Memory never ready: 16 request cycles then sticky error.
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("wait_req_%0d", i), {31'd0, req}, 32'd1);
      chk($sformatf("wait_err_%0d", i), {31'd0, err}, 32'd0);
    end
    step();
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_req", {31'd0, req}, 32'd0);
    chk("timeout_valid", {31'd0, valid}, 32'd0);

    // HALT is frozen against all inputs.
    ready = 1'b1;
    rdata = 32'hFFFF_FFFF;
    done  = 1'b1;
    jmp   = 1'b1;
    step();
    step();
    ready = 1'b0;
    done  = 1'b0;
    jmp   = 1'b0;
    chk("halt_err", {31'd0, err}, 32'd1);
    chk("halt_req", {31'd0, req}, 32'd0);
    chk("halt_valid", {31'd0, valid}, 32'd0);
    chk("halt_instr", instr, 32'h0000_0000);
    chk("halt_pc", pc, 32'h0000_0000);

    rst = 1'b1;
    step();
    chk("clear_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    step();
    chk("restart_req", {31'd0, req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
